// File: rtl/param_bank_ctrl_pkg.sv
// Shared constants, FSM encoding and saturating increment for the scene-parameter bank.
package param_bank_ctrl_pkg;

    localparam int NUM_BYTES = 55;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/param_bank_mem.sv
// Two parameter banks: one shadow (written by the loader), one active (read by the renderer).
module param_bank_mem
    import param_bank_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic       sel_q, sel_d;
    logic [7:0] bank_q [2][NUM_BYTES];
    logic [7:0] rd_data_q;

    // A write in the swap cycle lands in the bank that becomes shadow after the swap.
    assign sel_d = swap ? ~sel_q : sel_q;

    // NOTE: the banks are reset explicitly; the active bank is visible to the renderer
    // straight out of reset, so it must read as zero rather than power-up garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q     <= 1'b0;
            rd_data_q <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else begin
            sel_q <= sel_d;
            if (wr_en) begin
                bank_q[sel_d][wr_idx] <= wr_data;
            end
            rd_data_q <= (rd_idx < IDX_W'(NUM_BYTES)) ? bank_q[~sel_q][rd_idx] : '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_bank_ctrl.sv
// Frame loader front end: validates the incoming parameter frame and swaps banks on vsync.
module param_bank_ctrl
    import param_bank_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             update_reg,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       read_data,
    input  logic             pc_ready,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             commit,
    output logic             active_valid,
    output logic             pending,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] expect_q, expect_d;
    logic             seq_ok_q, seq_ok_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic [CNT_W-1:0] ferr_q, ferr_d;
    logic             commit_q, active_valid_q;
    logic             swap;
    logic             in_range;

    assign in_range = idx < IDX_W'(NUM_BYTES);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        seq_ok_d  = seq_ok_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        swap      = 1'b0;

        if (update_reg) begin
            if (idx == '0) begin
                expect_d = IDX_W'(1);
                seq_ok_d = 1'b1;
            end else if (in_range && idx == expect_q) begin
                expect_d = expect_q + IDX_W'(1);
            end else begin
                seq_ok_d = 1'b0;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (update_reg) begin
                    if (idx == '0) state_d = ST_LOADING;
                    else           ferr_d  = sat_inc(ferr_q);
                end
            end
            ST_LOADING: begin
                // pc_ready is judged against the sequence state including this cycle's byte.
                if (pc_ready) begin
                    if (seq_ok_d && expect_d == IDX_W'(NUM_BYTES)) begin
                        state_d = ST_PENDING;
                    end else begin
                        ferr_d  = sat_inc(ferr_q);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    swap = 1'b1;
                end else if (update_reg) begin
                    overrun_d = sat_inc(overrun_q);
                end
                if (frame_start || update_reg) begin
                    state_d = ST_IDLE;
                    if (update_reg) begin
                        if (idx == '0) state_d = ST_LOADING;
                        else           ferr_d  = sat_inc(ferr_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            expect_q       <= '0;
            seq_ok_q       <= 1'b0;
            overrun_q      <= '0;
            ferr_q         <= '0;
            commit_q       <= 1'b0;
            active_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            expect_q       <= expect_d;
            seq_ok_q       <= seq_ok_d;
            overrun_q      <= overrun_d;
            ferr_q         <= ferr_d;
            commit_q       <= swap;
            active_valid_q <= active_valid_q | swap;
        end
    end

    param_bank_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (update_reg && in_range),
        .wr_idx  (idx),
        .wr_data (read_data),
        .swap    (swap),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign commit        = commit_q;
    assign active_valid  = active_valid_q;
    assign pending       = (state_q == ST_PENDING);
    assign overrun_cnt   = overrun_q;
    assign frame_err_cnt = ferr_q;

endmodule

// File: tb/tb_param_bank_ctrl.sv
// Directed bench for param_bank_ctrl: read-back table plus hand-written multi-cycle sequences.
module tb_param_bank_ctrl;
    import param_bank_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             update_reg;
    logic [IDX_W-1:0] idx;
    logic [7:0]       read_data;
    logic             pc_ready;
    logic             frame_start;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_data;
    logic             commit;
    logic             active_valid;
    logic             pending;
    logic [CNT_W-1:0] overrun_cnt;
    logic [CNT_W-1:0] frame_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [IDX_W-1:0] ri;
        logic [7:0]       exp;
    } rd_vec_t;

    rd_vec_t rd_tab [6];

    param_bank_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .update_reg    (update_reg),
        .idx           (idx),
        .read_data     (read_data),
        .pc_ready      (pc_ready),
        .frame_start   (frame_start),
        .rd_idx        (rd_idx),
        .rd_data       (rd_data),
        .commit        (commit),
        .active_valid  (active_valid),
        .pending       (pending),
        .overrun_cnt   (overrun_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int i, input logic [7:0] d);
        update_reg = 1'b1;
        idx        = IDX_W'(i);
        read_data  = d;
        tick();
        update_reg = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int base);
        for (int i = lo; i <= hi; i++) send_byte(i, 8'(i + base));
    endtask

    task automatic pulse_pc();
        pc_ready = 1'b1;
        tick();
        pc_ready = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic read_check(input string name, input int i, input logic [7:0] exp);
        rd_idx = IDX_W'(i);
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rd_tab[0] = '{ri: 6'd0,  exp: 8'h10};
        rd_tab[1] = '{ri: 6'd1,  exp: 8'h11};
        rd_tab[2] = '{ri: 6'd30, exp: 8'h2E};
        rd_tab[3] = '{ri: 6'd54, exp: 8'h46};
        rd_tab[4] = '{ri: 6'd55, exp: 8'h00};
        rd_tab[5] = '{ri: 6'd63, exp: 8'h00};

        reset = 1'b1; update_reg = 1'b0; idx = '0; read_data = '0;
        pc_ready = 1'b0; frame_start = 1'b0; rd_idx = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_commit",  32'(commit),        32'd0);
        check("rst_valid",   32'(active_valid),  32'd0);
        check("rst_pending", 32'(pending),       32'd0);
        check("rst_overrun", 32'(overrun_cnt),   32'd0);
        check("rst_ferr",    32'(frame_err_cnt), 32'd0);
        read_check("rst_rd", 54, 8'h00);

        // Full frame, commit 10 cycles after pc_ready
        send_range(0, 54, 'h10);
        pulse_pc();
        check("f1_pending", 32'(pending), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("f1_pending_hold", 32'(pending), 32'd1);
        check("f1_no_commit",    32'(commit),  32'd0);
        pulse_fs();
        check("f1_commit",  32'(commit),       32'd1);
        check("f1_valid",   32'(active_valid), 32'd1);
        check("f1_pend0",   32'(pending),      32'd0);
        tick();
        check("f1_commit_once", 32'(commit), 32'd0);
        for (int v = 0; v < 6; v++) begin
            rd_idx = rd_tab[v].ri;
            tick();
            check($sformatf("f1_rd_%0d", rd_tab[v].ri), 32'(rd_data), 32'(rd_tab[v].exp));
        end

        // Frame with idx 21 missing
        send_range(0, 20, 'h70);
        send_range(22, 54, 'h70);
        pulse_pc();
        check("gap_ferr",    32'(frame_err_cnt), 32'd1);
        check("gap_pending", 32'(pending),       32'd0);
        pulse_fs();
        check("gap_no_commit", 32'(commit), 32'd0);
        read_check("gap_rd54", 54, 8'h46);
        read_check("gap_rd21", 21, 8'h25);

        // Frame A pending, overrun by frame B
        send_range(0, 54, 'h30);
        pulse_pc();
        check("ovr_a_pending", 32'(pending), 32'd1);
        send_byte(0, 8'hAA);
        check("ovr_cnt",  32'(overrun_cnt), 32'd1);
        check("ovr_pend", 32'(pending),     32'd0);
        for (int i = 1; i <= 54; i++) send_byte(i, 8'hAA);
        pulse_pc();
        check("ovr_b_pending", 32'(pending), 32'd1);
        pulse_fs();
        check("ovr_commit", 32'(commit), 32'd1);
        for (int i = 0; i < NUM_BYTES; i++) read_check($sformatf("ovr_rd_%0d", i), i, 8'hAA);
        check("ovr_ferr", 32'(frame_err_cnt), 32'd1);

        // frame_start and update_reg together while pending: commit wins
        send_range(0, 54, 'h50);
        pulse_pc();
        frame_start = 1'b1; update_reg = 1'b1; idx = '0; read_data = 8'h5C;
        tick();
        frame_start = 1'b0; update_reg = 1'b0;
        check("sim_commit",  32'(commit),      32'd1);
        check("sim_overrun", 32'(overrun_cnt), 32'd1);
        check("sim_pending", 32'(pending),     32'd0);
        read_check("sim_rd0_old", 0, 8'h50);

        // pc_ready and frame_start together: pend only, commit on the next frame_start
        send_range(1, 54, 'h60);
        pc_ready = 1'b1; frame_start = 1'b1;
        tick();
        pc_ready = 1'b0; frame_start = 1'b0;
        check("pcfs_no_commit", 32'(commit),  32'd0);
        check("pcfs_pending",   32'(pending), 32'd1);
        read_check("pcfs_rd0_old", 0, 8'h50);
        pulse_fs();
        check("pcfs_commit", 32'(commit), 32'd1);
        read_check("pcfs_rd0",  0,  8'h5C);
        read_check("pcfs_rd1",  1,  8'h61);
        read_check("pcfs_rd54", 54, 8'h96);
        check("pcfs_ferr", 32'(frame_err_cnt), 32'd1);

        // Out-of-range idx inside a frame invalidates it
        send_range(0, 54, 'h10);
        send_byte(60, 8'hEE);
        pulse_pc();
        check("oor_ferr",    32'(frame_err_cnt), 32'd2);
        check("oor_pending", 32'(pending),       32'd0);

        // Reset in the middle of a frame
        send_range(0, 30, 'h20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_commit",  32'(commit),        32'd0);
        check("mrst_valid",   32'(active_valid),  32'd0);
        check("mrst_pending", 32'(pending),       32'd0);
        check("mrst_overrun", 32'(overrun_cnt),   32'd0);
        check("mrst_ferr",    32'(frame_err_cnt), 32'd0);
        for (int i = 0; i < NUM_BYTES; i++) read_check($sformatf("mrst_rd_%0d", i), i, 8'h00);

        send_range(0, 54, 'h10);
        pulse_pc();
        pulse_fs();
        check("post_commit", 32'(commit),        32'd1);
        check("post_valid",  32'(active_valid),  32'd1);
        check("post_ferr",   32'(frame_err_cnt), 32'd0);
        read_check("post_rd0",  0,  8'h10);
        read_check("post_rd54", 54, 8'h46);

        // Error counter saturates at 255
        for (int i = 0; i < 260; i++) send_byte(5, 8'h00);
        check("sat_ferr",    32'(frame_err_cnt), 32'd255);
        check("sat_pending", 32'(pending),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
